// File: rtl/mem_host_loader.sv
// Host-side burst loader, readback port and run supervisor sitting between the
// host, the unified instruction/data memory and the multicycle CPU core.
module mem_host_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 3,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              Ld_Valid,
  input  logic              Ld_First,
  input  logic [ADDR_W-1:0] Ld_Addr,
  input  logic [DATA_W-1:0] Ld_Data,
  output logic              Ld_Ready,
  input  logic              Rb_Req,
  input  logic [ADDR_W-1:0] Rb_Addr,
  output logic              Rb_Ready,
  output logic              Rb_Valid,
  output logic [DATA_W-1:0] Rb_Data,
  input  logic              Run_Start,
  input  logic              Run_Abort,
  output logic              Cpu_Rst,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic [DATA_W-1:0] Cpu_WData,
  input  logic              Cpu_WE,
  input  logic              Cpu_Done,
  output logic [ADDR_W-1:0] MEM_Addr,
  output logic [DATA_W-1:0] MEM_WData,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_RData,
  output logic              Busy,
  output logic              Halted,
  output logic              Timeout,
  output logic              Aborted,
  output logic [CNT_W-1:0]  Run_Cycles
);

  typedef enum logic [1:0] {IDLE, RSTHOLD, RUN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } mem_req_t;

  localparam int               RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam bit               TMO_EN   = (MAX_CYCLES != 0);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [RC_W-1:0]   rst_cnt;
  logic              rb_pend;
  logic [DATA_W-1:0] rb_hold;

  logic              host, beat, rb_acc, start_acc;
  logic [ADDR_W-1:0] beat_addr;
  mem_req_t          req;

  // Host ownership is gated by Rst_n so handshakes drop the instant reset asserts.
  assign host      = Rst_n & ((state == IDLE) | (state == DONE));
  assign Ld_Ready  = host & ~rb_pend;
  assign beat      = Ld_Valid & Ld_Ready;
  assign Rb_Ready  = Rb_Req & host & ~Ld_Valid & ~rb_pend;
  assign rb_acc    = Rb_Ready;
  assign start_acc = Run_Start & host & ~beat & ~rb_acc;
  assign beat_addr = Ld_First ? Ld_Addr : ptr;

  always_comb begin
    req = '0;
    if (state == RUN)
      req = '{addr: Cpu_Addr, wdata: Cpu_WData, we: Cpu_WE};
    else if (beat)
      req = '{addr: beat_addr, wdata: Ld_Data, we: 1'b1};
    else if (rb_acc)
      req.addr = Rb_Addr;
  end

  assign MEM_Addr  = req.addr;
  assign MEM_WData = req.wdata;
  assign MEM_WE    = req.we;

  // CPU reset is a pure state decode, so it reasserts in the very cycle DONE is entered.
  assign Cpu_Rst  = (state != RUN);
  assign Busy     = (state == RSTHOLD) | (state == RUN);
  assign Rb_Valid = rb_pend;
  assign Rb_Data  = rb_pend ? MEM_RData : rb_hold;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      rst_cnt    <= '0;
      rb_pend    <= 1'b0;
      rb_hold    <= '0;
      Halted     <= 1'b0;
      Timeout    <= 1'b0;
      Aborted    <= 1'b0;
      Run_Cycles <= '0;
    end else begin
      rb_pend <= rb_acc;
      if (rb_pend) rb_hold <= MEM_RData;
      if (beat)    ptr     <= beat_addr + ADDR_W'(1);

      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            state      <= RSTHOLD;
            rst_cnt    <= '0;
            Halted     <= 1'b0;
            Timeout    <= 1'b0;
            Aborted    <= 1'b0;
            Run_Cycles <= '0;
          end
        end
        RSTHOLD: begin
          if (Run_Abort) begin
            state   <= DONE;
            Aborted <= 1'b1;
          end else if (rst_cnt == RC_LAST) begin
            state <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        RUN: begin
          // The exit cycle is itself a RUN cycle, so it is counted too.
          if (~&Run_Cycles) Run_Cycles <= Run_Cycles + CNT_W'(1);
          if (Run_Abort) begin
            state   <= DONE;
            Aborted <= 1'b1;
          end else if (Cpu_Done) begin
            state  <= DONE;
            Halted <= 1'b1;
          end else if (TMO_EN && (Run_Cycles == TMO_LAST)) begin
            state   <= DONE;
            Timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_host_loader.sv
// Scoreboarded bench for mem_host_loader: behavioural sync memory, a scripted
// CPU stub, directed bursts/readbacks/runs, and a decoupled readback monitor.
module tb_mem_host_loader;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        Ld_Valid, Ld_First;
  logic [7:0]  Ld_Addr;
  logic [15:0] Ld_Data;
  logic        Ld_Ready;
  logic        Rb_Req;
  logic [7:0]  Rb_Addr;
  logic        Rb_Ready, Rb_Valid;
  logic [15:0] Rb_Data;
  logic        Run_Start, Run_Abort, Cpu_Rst;
  logic [7:0]  Cpu_Addr;
  logic [15:0] Cpu_WData;
  logic        Cpu_WE, Cpu_Done;
  logic [7:0]  MEM_Addr;
  logic [15:0] MEM_WData;
  logic        MEM_WE;
  logic [15:0] MEM_RData;
  logic        Busy, Halted, Timeout, Aborted;
  logic [15:0] Run_Cycles;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int w, h, r;
  int cpu_mode;

  always #5 clk = ~clk;

  mem_host_loader #(
    .DATA_W(16), .ADDR_W(8), .RST_CYCLES(3), .CNT_W(16), .MAX_CYCLES(50)
  ) dut (
    .clk(clk), .Rst_n(Rst_n),
    .Ld_Valid(Ld_Valid), .Ld_First(Ld_First), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data),
    .Ld_Ready(Ld_Ready),
    .Rb_Req(Rb_Req), .Rb_Addr(Rb_Addr), .Rb_Ready(Rb_Ready), .Rb_Valid(Rb_Valid),
    .Rb_Data(Rb_Data),
    .Run_Start(Run_Start), .Run_Abort(Run_Abort), .Cpu_Rst(Cpu_Rst),
    .Cpu_Addr(Cpu_Addr), .Cpu_WData(Cpu_WData), .Cpu_WE(Cpu_WE), .Cpu_Done(Cpu_Done),
    .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData), .MEM_WE(MEM_WE), .MEM_RData(MEM_RData),
    .Busy(Busy), .Halted(Halted), .Timeout(Timeout), .Aborted(Aborted),
    .Run_Cycles(Run_Cycles)
  );

  // Unified memory, one-cycle synchronous read.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (MEM_WE) mem[MEM_Addr] <= MEM_WData;
    MEM_RData <= mem[MEM_Addr];
  end

  // CPU stub. Mode 0: MEM[90] = MEM[80] + MEM[81], then HLT. Mode 1: spin at 0.
  int step;
  logic [15:0] ca, cb;
  always @(posedge clk) begin
    if (Cpu_Rst) step <= 0;
    else begin
      step <= step + 1;
      if (step == 1) ca <= MEM_RData;
      if (step == 2) cb <= MEM_RData;
    end
  end
  always_comb begin
    Cpu_Addr = 8'h00; Cpu_WData = 16'h0; Cpu_WE = 1'b0; Cpu_Done = 1'b0;
    if (cpu_mode == 0) begin
      if (step == 0) Cpu_Addr = 8'h80;
      if (step == 1) Cpu_Addr = 8'h81;
      if (step == 3) begin Cpu_Addr = 8'h90; Cpu_WData = ca + cb; Cpu_WE = 1'b1; end
      if (step >= 4) Cpu_Done = ~Cpu_Rst;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Readback monitor: every Rb_Valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (Rst_n && Rb_Valid) begin
      if (exp_q.size() == 0) chk("rb_unexpected", 1, 0);
      else chk("rb_data", Rb_Data, exp_q.pop_front());
    end
  end

  task automatic beat(input logic first, input logic [7:0] a, input logic [15:0] d,
                      input logic [7:0] exp_addr);
    @(negedge clk);
    Ld_Valid = 1'b1; Ld_First = first; Ld_Addr = a; Ld_Data = d;
    #1;
    chk("ld_ready", Ld_Ready, 1);
    chk("beat_we", MEM_WE, 1);
    chk("beat_addr", MEM_Addr, exp_addr);
    chk("beat_wdata", MEM_WData, d);
    @(posedge clk); #1;
    Ld_Valid = 1'b0; Ld_First = 1'b0;
  endtask

  task automatic readback(input logic [7:0] a, input logic [15:0] exp, output int waits);
    waits = 0;
    @(negedge clk);
    Rb_Req = 1'b1; Rb_Addr = a;
    #1;
    while (!Rb_Ready && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    if (!Rb_Ready) begin
      chk("rb_accept_timeout", 0, 1);
      Rb_Req = 1'b0;
      return;
    end
    chk("rb_mem_addr", {MEM_WE, MEM_Addr}, {1'b0, a});
    exp_q.push_back(exp);
    @(posedge clk); #1;
    Rb_Req = 1'b0;
    @(negedge clk);
    chk("rb_latency", Rb_Valid, 1);
  endtask

  task automatic run_start();
    @(negedge clk);
    Run_Start = 1'b1;
    @(posedge clk); #1;
    Run_Start = 1'b0;
  endtask

  task automatic run_wait(output int hold_n, output int run_n);
    hold_n = 0; run_n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!Busy) break;
      if (Cpu_Rst) hold_n++; else run_n++;
    end
    if (Busy) chk("run_wait_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0; Ld_Valid = 1'b0; Ld_First = 1'b0; Ld_Addr = '0; Ld_Data = '0;
    Rb_Req = 1'b0; Rb_Addr = '0; Run_Start = 1'b0; Run_Abort = 1'b0; cpu_mode = 1;
    #3;
    chk("rst_cpu_rst", Cpu_Rst, 1);
    chk("rst_outs", {Ld_Ready, Rb_Ready, Rb_Valid, Busy, Halted, Timeout, Aborted, MEM_WE}, 0);
    chk("rst_cycles", Run_Cycles, 0);
    chk("rst_rb_data", Rb_Data, 0);
    repeat (2) @(negedge clk);
    Rst_n = 1'b1;

    // Wrapping burst from FE.
    beat(1, 8'hFE, 16'd1, 8'hFE);
    beat(0, 8'h00, 16'd2, 8'hFF);
    beat(0, 8'h00, 16'd3, 8'h00);
    beat(0, 8'h00, 16'd4, 8'h01);
    beat(0, 8'h00, 16'd5, 8'h02);
    readback(8'h01, 16'h0004, w);
    readback(8'hFE, 16'h0001, w);
    readback(8'hFF, 16'h0002, w);
    readback(8'h00, 16'h0003, w);
    readback(8'h02, 16'h0005, w);

    // Write beats beat a same-cycle read; the read goes through next cycle.
    @(negedge clk);
    Ld_Valid = 1'b1; Ld_First = 1'b1; Ld_Addr = 8'h10; Ld_Data = 16'h00AA;
    Rb_Req = 1'b1; Rb_Addr = 8'h10;
    #1;
    chk("conflict_rb_ready", Rb_Ready, 0);
    chk("conflict_write", {Ld_Ready, MEM_WE, MEM_Addr}, {2'b11, 8'h10});
    @(posedge clk); #1;
    Ld_Valid = 1'b0;
    readback(8'h10, 16'h00AA, w);
    chk("conflict_rb_next", w, 0);

    // Run_Start alongside an accepted beat is ignored; the beat loads MEM[80].
    @(negedge clk);
    Ld_Valid = 1'b1; Ld_First = 1'b1; Ld_Addr = 8'h80; Ld_Data = 16'h0064; Run_Start = 1'b1;
    @(posedge clk); #1;
    Ld_Valid = 1'b0; Run_Start = 1'b0;
    @(negedge clk);
    chk("start_with_beat_ignored", Busy, 0);
    beat(0, 8'h00, 16'h0001, 8'h81);

    // Add program run to HLT.
    cpu_mode = 0;
    run_start();
    run_wait(h, r);
    chk("add_hold_cycles", h, 3);
    chk("add_run_cycles_seen", r, 5);
    chk("add_flags", {Halted, Timeout, Aborted, Cpu_Rst}, 4'b1001);
    chk("add_cycles", Run_Cycles, 5);
    repeat (4) @(negedge clk);
    chk("add_cycles_frozen", Run_Cycles, 5);
    readback(8'h90, 16'h0065, w);

    // Infinite loop hits the 50-cycle limit.
    cpu_mode = 1;
    run_start();
    run_wait(h, r);
    chk("tmo_run_cycles_seen", r, 50);
    chk("tmo_flags", {Halted, Timeout, Aborted, Cpu_Rst}, 4'b0101);
    chk("tmo_cycles", Run_Cycles, 50);

    // Abort on the 10th RUN cycle; host writes are locked out while running.
    run_start();
    repeat (3) @(negedge clk);
    chk("hold_flags_cleared", {Busy, Cpu_Rst, Timeout}, 3'b110);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) chk("run_entered", {Busy, Cpu_Rst}, 2'b10);
      if (n == 2) begin
        Ld_Valid = 1'b1; Ld_First = 1'b1; Ld_Addr = 8'h80; Ld_Data = 16'hDEAD;
        #1;
        chk("run_ld_blocked", {Ld_Ready, MEM_WE}, 2'b00);
      end
      if (n == 3) Ld_Valid = 1'b0;
      if (n == 10) Run_Abort = 1'b1;
    end
    @(posedge clk); #1;
    Run_Abort = 1'b0;
    @(negedge clk);
    chk("abort_flags", {Busy, Halted, Timeout, Aborted, Cpu_Rst}, 5'b00011);
    chk("abort_cycles", Run_Cycles, 10);
    readback(8'h80, 16'h0064, w);

    // Abort during the CPU reset hold.
    run_start();
    @(negedge clk);
    Run_Abort = 1'b1;
    @(posedge clk); #1;
    Run_Abort = 1'b0;
    @(negedge clk);
    chk("hold_abort", {Busy, Aborted}, 2'b01);
    chk("hold_abort_cycles", Run_Cycles, 0);

    // Reset in the middle of a burst.
    beat(1, 8'h20, 16'h0011, 8'h20);
    beat(0, 8'h00, 16'h0022, 8'h21);
    @(negedge clk);
    Ld_Valid = 1'b1; Ld_First = 1'b0; Ld_Data = 16'h0033; Rst_n = 1'b0;
    #1;
    chk("midburst_rst", {Ld_Ready, MEM_WE, Cpu_Rst, Aborted}, 4'b0010);
    Ld_Valid = 1'b0;
    @(negedge clk);
    Rst_n = 1'b1;
    beat(0, 8'h00, 16'h0044, 8'h00);
    readback(8'h20, 16'h0011, w);
    readback(8'h21, 16'h0022, w);
    readback(8'h00, 16'h0044, w);
    readback(8'hFF, 16'h0002, w);

    // Reset in the middle of a run.
    run_start();
    repeat (6) @(negedge clk);
    chk("midrun_running", {Busy, Cpu_Rst}, 2'b10);
    Rst_n = 1'b0;
    #1;
    chk("midrun_rst", {Busy, Cpu_Rst, Halted, Timeout, Aborted}, 5'b01000);
    chk("midrun_cycles", Run_Cycles, 0);
    @(negedge clk);
    Rst_n = 1'b1;

    // A response pending at reset is dropped.
    @(negedge clk);
    Rb_Req = 1'b1; Rb_Addr = 8'h21;
    #1;
    chk("drop_accept", Rb_Ready, 1);
    @(posedge clk); #1;
    Rb_Req = 1'b0; Rst_n = 1'b0;
    #1;
    chk("drop_rb_valid", Rb_Valid, 0);
    @(negedge clk);
    Rst_n = 1'b1;
    readback(8'hFE, 16'h0001, w);
    readback(8'h90, 16'h0065, w);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
